// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locking arbiter sharing one UART TX FIFO write port
// between NUM_REQ requesters, with a per-grant byte budget and an idle timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 flush_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           fifo_data_o,
  output logic                 fifo_valid_o,
  input  logic                 fifo_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, LOCK} state_e;
  state_e        state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d, rr_ptr_q, rr_ptr_d, sel, k;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, accept, release_lock;
  assign grant_o      = (state_q == LOCK) ? NUM_REQ'(1) << gidx_q : '0;
  assign req_ready_o  = grant_o & {NUM_REQ{(~valid_q | fifo_ready_i) & ~flush_i}};
  assign accept       = |(req_ready_o & req_valid_i);
  assign fifo_data_o  = data_q;
  assign fifo_valid_o = valid_q;
  assign busy_o       = state_q == LOCK;
  // Scan downward in offset so the lowest offset from rr_ptr wins.
  always_comb begin
    sel = rr_ptr_q;
    k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      sel = req_valid_i[k] ? k : sel;
    end
  end
  always_comb begin
    state_d = state_q;
    gidx_d = gidx_q;
    rr_ptr_d = rr_ptr_q;
    burst_d = burst_q;
    idle_d = idle_q;
    release_lock = 1'b0;
    data_d = accept ? req_data_i[{gidx_q, 3'b000} +: 8] : data_q;
    valid_d = accept | (valid_q & ~fifo_ready_i);
    if (flush_i) begin
      state_d = IDLE;
      burst_d = '0;
      idle_d = '0;
      valid_d = 1'b0;
    end else if (state_q == IDLE) begin
      burst_d = '0;
      idle_d = '0;
      state_d = |req_valid_i ? LOCK : IDLE;
      gidx_d = |req_valid_i ? sel : gidx_q;
    end else begin
      burst_d = accept ? burst_q + BW'(1) : burst_q;
      idle_d = accept ? '0 : (!req_valid_i[gidx_q] && idle_q != TW'(TIMEOUT)) ? idle_q + TW'(1) : idle_q;
      release_lock = (accept && (req_last_i[gidx_q] || burst_d == BW'(MAX_BURST))) || idle_d == TW'(TIMEOUT);
      state_d = release_lock ? IDLE : LOCK;
      rr_ptr_d = release_lock ? IW'((int'(gidx_q) + 1) % NUM_REQ) : rr_ptr_q;
    end
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= IDLE;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      idle_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      idle_q   <= idle_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic checked against per-requester
// byte-order scoreboards; bytes carry {requester id, sequence number}.
module tb_uart_tx_arbiter;
  localparam int MB = 4, TO = 8;
  logic clk = 1'b0, arst_n, flush, fready, fvalid, busy;
  logic [15:0] data;
  logic [1:0] valid, last, ready, grant, en, rdy_seen, prev_g;
  logic [7:0] fdata;
  logic [8:0] q0[$], q1[$];
  logic [7:0] outq[$];
  int stamp[$];
  logic [1:0] glog[$];
  int cyc, n_chk, n_err, run, acc_total, out_total;
  logic [6:0] seq_in[2], seq_out[2];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk_i(clk), .arst_ni(arst_n), .flush_i(flush),
    .req_data_i(data), .req_valid_i(valid), .req_last_i(last), .req_ready_o(ready),
    .fifo_data_o(fdata), .fifo_valid_o(fvalid), .fifo_ready_i(fready),
    .grant_o(grant), .busy_o(busy)
  );

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] h0, h1;
    h0 = q0.size() > 0 ? q0[0] : 9'h000;
    h1 = q1.size() > 0 ? q1[0] : 9'h000;
    valid[0] = en[0] && q0.size() > 0;
    valid[1] = en[1] && q1.size() > 0;
    data = {h1[7:0], h0[7:0]};
    last = {h1[8], h0[8]};
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    glog.push_back(grant);
    rdy_seen = ready;
    chk("rdy_in_gnt", int'(ready & ~grant), 0);
    chk("gnt_onehot", int'($countones(grant) <= 1), 1);
    if (fvalid && fready) begin
      outq.push_back(fdata);
      stamp.push_back(cyc);
    end
    if (grant != prev_g) run = 0;
    prev_g = grant;
    if (valid[0] && ready[0]) begin void'(q0.pop_front()); run++; acc_total++; end
    if (valid[1] && ready[1]) begin void'(q1.pop_front()); run++; acc_total++; end
    if (|(valid & ready)) chk("burst_cap", int'(run <= MB), 1);
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clr();
    outq.delete();
    stamp.delete();
    glog.delete();
  endtask

  task automatic run_till_done(int maxc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || fvalid || busy) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) chk("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    flush = 1'b0;
    fready = 1'b1;
    en = 2'b11;
    q0.delete();
    q1.delete();
    clr();
    acc_total = 0;
    run = 0;
    prev_g = 2'b00;
    drive();
    #1;
    chk("rst_fvalid", int'(fvalid), 0);
    chk("rst_fdata", int'(fdata), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic int oq(int i);
    return i < outq.size() ? int'(outq[i]) : -1;
  endfunction

  function automatic int st(int i);
    return i < stamp.size() ? stamp[i] : -100;
  endfunction

  function automatic int gcount(logic [1:0] g);
    int c = 0;
    foreach (glog[i]) if (glog[i] == g) c++;
    return c;
  endfunction

  function automatic int gap_before(logic [1:0] g);
    int c = 0;
    int idx = -1;
    foreach (glog[i]) if (idx < 0 && glog[i] == g) idx = i;
    if (idx < 0) return -1;
    for (int j = idx - 1; j >= 0 && glog[j] == 2'b00; j--) c++;
    return c;
  endfunction

  task automatic push_msg(int r, int len);
    for (int i = 0; i < len; i++) begin
      logic [8:0] b;
      b = {i == len - 1, r[0], seq_in[r]};
      seq_in[r] = seq_in[r] + 7'd1;
      if (r == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    arst_n = 1'b0;
    // single message, then a follow-up contention showing rr_ptr moved to 1
    do_reset();
    q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h143);
    drive();
    run_till_done(40);
    chk("t1_n", outq.size(), 3);
    chk("t1_b0", oq(0), 'h41);
    chk("t1_b1", oq(1), 'h42);
    chk("t1_b2", oq(2), 'h43);
    chk("t1_consec", st(2) - st(0), 2);
    chk("t1_gnt_cycles", gcount(2'b01), 3);
    chk("t1_gnt_end", int'(grant), 0);
    clr();
    q0.push_back(9'h171); q1.push_back(9'h172);
    drive();
    run_till_done(40);
    chk("rr_first", oq(0), 'h72);
    chk("rr_second", oq(1), 'h71);
    // contention from reset
    do_reset();
    q0.push_back(9'h0A0); q0.push_back(9'h1A1);
    q1.push_back(9'h0B0); q1.push_back(9'h1B1);
    drive();
    run_till_done(40);
    chk("t2_n", outq.size(), 4);
    chk("t2_b0", oq(0), 'hA0);
    chk("t2_b1", oq(1), 'hA1);
    chk("t2_b2", oq(2), 'hB0);
    chk("t2_b3", oq(3), 'hB1);
    chk("t2_idle_gap", gap_before(2'b10), 1);
    chk("t2_out_gap", st(2) - st(1), 2);
    // burst budget
    do_reset();
    for (int i = 1; i <= 6; i++) q0.push_back({i == 6, 8'(i)});
    q1.push_back(9'h155);
    drive();
    run_till_done(60);
    chk("t3_n", outq.size(), 7);
    for (int i = 0; i < 4; i++) chk("t3_first4", oq(i), i + 1);
    chk("t3_req1", oq(4), 'h55);
    chk("t3_rest0", oq(5), 5);
    chk("t3_rest1", oq(6), 6);
    // idle timeout, then continuation of the cut message
    do_reset();
    q0.push_back(9'h021);
    q1.push_back(9'h131);
    drive();
    run_till_done(60);
    chk("t4_gnt0_cycles", gcount(2'b01), 1 + TO);
    chk("t4_idle_gap", gap_before(2'b10), 1);
    chk("t4_b0", oq(0), 'h21);
    chk("t4_b1", oq(1), 'h31);
    q0.push_back(9'h122);
    drive();
    run_till_done(40);
    chk("t4_cont", oq(2), 'h22);
    // backpressure
    do_reset();
    fready = 1'b0;
    q0.push_back(9'h010); q0.push_back(9'h011); q0.push_back(9'h012); q0.push_back(9'h113);
    drive();
    repeat (7) step();
    chk("t5_hold_data", int'(fdata), 'h10);
    chk("t5_hold_valid", int'(fvalid), 1);
    chk("t5_ready", int'(ready), 0);
    chk("t5_rdy_seen", int'(rdy_seen), 0);
    chk("t5_none_out", outq.size(), 0);
    fready = 1'b1;
    drive();
    run_till_done(40);
    chk("t5_n", outq.size(), 4);
    for (int i = 0; i < 4; i++) chk("t5_seq", oq(i), 'h10 + i);
    chk("t5_consec", st(3) - st(0), 3);
    // flush mid-message with a held byte
    do_reset();
    fready = 1'b0;
    q0.push_back(9'h061); q0.push_back(9'h062); q0.push_back(9'h163);
    drive();
    repeat (4) step();
    flush = 1'b1;
    step();
    chk("fl_ready", int'(rdy_seen), 0);
    flush = 1'b0;
    chk("fl_fvalid", int'(fvalid), 0);
    chk("fl_grant", int'(grant), 0);
    chk("fl_busy", int'(busy), 0);
    fready = 1'b1;
    drive();
    run_till_done(40);
    chk("fl_n", outq.size(), 2);
    chk("fl_b0", oq(0), 'h62);
    chk("fl_b1", oq(1), 'h63);
    // asynchronous reset mid-message
    do_reset();
    for (int i = 0; i < 5; i++) q0.push_back({i == 4, 8'(8'h81 + i)});
    drive();
    repeat (3) step();
    arst_n = 1'b0;
    #1;
    chk("ar_fvalid", int'(fvalid), 0);
    chk("ar_fdata", int'(fdata), 0);
    chk("ar_grant", int'(grant), 0);
    chk("ar_ready", int'(ready), 0);
    chk("ar_busy", int'(busy), 0);
    // randomized traffic against per-requester order scoreboards
    do_reset();
    seq_in[0] = '0; seq_in[1] = '0; seq_out[0] = '0; seq_out[1] = '0;
    out_total = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if ((r == 0 ? q0.size() : q1.size()) < 3 && $urandom_range(0, 3) == 0)
          push_msg(r, int'($urandom_range(1, 7)));
        if ($urandom_range(0, 15) == 0) en[r] = ~en[r];
      end
      fready = $urandom_range(0, 3) != 0;
      drive();
      step();
      while (outq.size() > 0) begin
        logic [7:0] b;
        b = outq.pop_front();
        chk("rnd_order", int'(b[6:0]), int'(seq_out[b[7]]));
        seq_out[b[7]] = b[6:0] + 7'd1;
        out_total++;
      end
    end
    en = 2'b11;
    fready = 1'b1;
    drive();
    run_till_done(600);
    while (outq.size() > 0) begin
      logic [7:0] b;
      b = outq.pop_front();
      chk("rnd_order", int'(b[6:0]), int'(seq_out[b[7]]));
      seq_out[b[7]] = b[6:0] + 7'd1;
      out_total++;
    end
    chk("rnd_total", out_total, acc_total);
    chk("rnd_all0", int'(seq_out[0]), int'(seq_in[0]));
    chk("rnd_all1", int'(seq_out[1]), int'(seq_in[1]));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
